// File: rtl/store_buf_pkg.sv
// store_buf_pkg: shared entry type and lane constants for the store buffer.
package store_buf_pkg;
  localparam int BE_W = 4;
  typedef struct packed {
    logic [31:0]     addr;
    logic [31:0]     data;
    logic [BE_W-1:0] be;
    logic [31:0]     pc;
  } sb_entry_t;
endpackage

// File: rtl/sb_fwd_lookup.sv
// sb_fwd_lookup: per-byte-lane youngest-match select over the store buffer entries.
module sb_fwd_lookup
  import store_buf_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PW    = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0] i_valid,
  input  sb_entry_t        i_entries [DEPTH],
  input  logic [PW-1:0]    i_head,
  output logic [31:0]      o_data,
  output logic [BE_W-1:0]  o_be
);
  logic [DEPTH-1:0] w_unused_fields;
  for (genvar i = 0; i < DEPTH; i++) begin : g_unused
    assign w_unused_fields[i] = |{i_entries[i].addr, i_entries[i].pc};
  end
  // Walk entries oldest to youngest so the youngest covering entry wins each lane
  always_comb begin
    o_data = '0;
    o_be   = '0;
    for (int k = 0; k < DEPTH; k++)
      for (int l = 0; l < BE_W; l++)
        if (i_valid[i_head + PW'(k)] && i_entries[i_head + PW'(k)].be[l]) begin
          o_data[8*l +: 8] = i_entries[i_head + PW'(k)].data[8*l +: 8];
          o_be[l]          = 1'b1;
        end
  end
endmodule

// File: rtl/store_buffer.sv
// store_buffer: posted-write FIFO from the CPU store port to data memory, with load hazard lookup.
// Build option: define STORE_BUF_FWD_EN for byte-lane store-to-load forwarding; otherwise matching loads stall.
module store_buffer
  import store_buf_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             st_valid,
  output logic             st_ready,
  input  logic [31:0]      st_addr,
  input  logic [31:0]      st_data,
  input  logic [BE_W-1:0]  st_be,
  input  logic [31:0]      st_pc,
  input  logic             ld_valid,
  input  logic [31:0]      ld_addr,
  output logic [31:0]      ld_data,
  output logic [BE_W-1:0]  ld_be,
  output logic             ld_stall,
  output logic             mem_we,
  input  logic             mem_ready,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_data,
  output logic [BE_W-1:0]  mem_be,
  output logic [31:0]      mem_pc,
  output logic             empty,
  output logic [CNT_W-1:0] count
);
  localparam int          PW      = $clog2(DEPTH);
  localparam logic [PW:0] PTR_ONE = (PW+1)'(1);

  sb_entry_t        r_mem [DEPTH];
  logic [PW:0]      r_head, r_tail;
  logic [PW:0]      w_used;
  logic             w_full, w_push, w_pop;
  logic [DEPTH-1:0] w_match;
  sb_entry_t        w_head;
  logic             w_unused_ld_lsb;

  assign w_used          = r_tail - r_head;
  assign empty           = r_head == r_tail;
  assign w_full          = (r_head[PW-1:0] == r_tail[PW-1:0]) && (r_head[PW] != r_tail[PW]);
  assign count           = CNT_W'(w_used);
  assign w_pop           = !empty && mem_ready;
  assign st_ready        = !w_full || w_pop;
  assign w_push          = st_valid && st_ready;
  assign mem_we          = !empty;
  assign w_head          = r_mem[r_head[PW-1:0]];
  assign mem_addr        = w_head.addr;
  assign mem_data        = w_head.data;
  assign mem_be          = w_head.be;
  assign mem_pc          = w_head.pc;
  assign w_unused_ld_lsb = |ld_addr[1:0];

  // An entry is live when its distance from head is below the fill level; the popping head still counts
  for (genvar i = 0; i < DEPTH; i++) begin : g_match
    assign w_match[i] = ({1'b0, PW'(i) - r_head[PW-1:0]} < w_used) &&
                        (r_mem[i].addr[31:2] == ld_addr[31:2]);
  end

  // Capture accepted stores at the tail slot
  always_ff @(posedge clk)
    if (w_push) r_mem[r_tail[PW-1:0]] <= '{st_addr, st_data, st_be, st_pc};

  // Advance tail on accepted stores and head on memory-accepted writes; reset drops all pending entries
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_head <= '0;
      r_tail <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + PTR_ONE;
      if (w_pop)  r_head <= r_head + PTR_ONE;
    end

`ifdef STORE_BUF_FWD_EN
  logic [31:0]     w_fwd_data;
  logic [BE_W-1:0] w_fwd_be;
  sb_fwd_lookup #(.DEPTH(DEPTH)) u_fwd (
    .i_valid   (w_match),
    .i_entries (r_mem),
    .i_head    (r_head[PW-1:0]),
    .o_data    (w_fwd_data),
    .o_be      (w_fwd_be)
  );
  assign ld_data  = ld_valid ? w_fwd_data : '0;
  assign ld_be    = ld_valid ? w_fwd_be : '0;
  assign ld_stall = 1'b0;
`else
  assign ld_data  = '0;
  assign ld_be    = '0;
  assign ld_stall = ld_valid && |w_match;
`endif
endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: randomized self-checking bench for store_buffer against a queue-based reference model.
module tb_store_buffer;
  import store_buf_pkg::*;
  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH+1);

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic st_valid = 1'b0, st_ready;
  logic [31:0] st_addr = '0, st_data = '0, st_pc = '0;
  logic [3:0] st_be = '0;
  logic ld_valid = 1'b0;
  logic [31:0] ld_addr = '0, ld_data;
  logic [3:0] ld_be;
  logic ld_stall;
  logic mem_we, mem_ready = 1'b0;
  logic [31:0] mem_addr, mem_data, mem_pc;
  logic [3:0] mem_be;
  logic empty;
  logic [CNT_W-1:0] count;

  int n_checks = 0;
  int n_fail = 0;
  sb_entry_t q[$];

  always #5 clk = ~clk;

  store_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr), .st_data(st_data), .st_be(st_be), .st_pc(st_pc),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_be(ld_be), .ld_stall(ld_stall),
    .mem_we(mem_we), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data), .mem_be(mem_be), .mem_pc(mem_pc),
    .empty(empty), .count(count)
  );

  task automatic drive(input logic sv, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                       input logic mr, input logic lv, input logic [31:0] la);
    st_valid = sv; st_addr = a; st_data = d; st_be = be; st_pc = $urandom();
    mem_ready = mr; ld_valid = lv; ld_addr = la;
    #1;
  endtask

  task automatic tick();
    logic pop, push;
    sb_entry_t e;
    pop  = rst && q.size() > 0 && mem_ready;
    push = rst && st_valid && (q.size() < DEPTH || pop);
    e = '{st_addr, st_data, st_be, st_pc};
    @(posedge clk);
    if (pop) void'(q.pop_front());
    if (push) q.push_back(e);
    @(negedge clk);
  endtask

  function automatic void model_ld(output logic [3:0] b, output logic [31:0] d, output logic s);
    logic hit;
    hit = 1'b0; b = '0; d = '0;
    if (ld_valid)
      foreach (q[k])
        if (q[k].addr[31:2] == ld_addr[31:2]) begin
          hit = 1'b1;
          for (int l = 0; l < 4; l++)
            if (q[k].be[l]) begin b[l] = 1'b1; d[8*l +: 8] = q[k].data[8*l +: 8]; end
        end
`ifdef STORE_BUF_FWD_EN
    s = 1'b0;
`else
    s = hit; b = '0; d = '0;
`endif
  endfunction

  task automatic test_reset();
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 1, 32'h40);
    n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b want 1", empty); end
    n_checks++; if (count !== '0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
    n_checks++; if (st_ready !== 1'b1) begin n_fail++; $display("FAIL reset_st_ready: got %b want 1", st_ready); end
    n_checks++; if (ld_be !== 4'h0 || ld_data !== 32'h0 || ld_stall !== 1'b0) begin n_fail++; $display("FAIL reset_ld: got be=%h data=%h stall=%b want 0/0/0", ld_be, ld_data, ld_stall); end
    tick();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin drive(1, 32'h80 + 32'(4*i), $urandom(), 4'hF, 0, 0, 0); tick(); end
    drive(0, 0, 0, 0, 0, 0, 0);
    n_checks++; if (count !== 3'd3) begin n_fail++; $display("FAIL prereset_count: got %0d want 3", count); end
    rst = 1'b0;
    #1;
    q.delete();
    n_checks++; if (mem_we !== 1'b0 || empty !== 1'b1 || count !== '0 || st_ready !== 1'b1) begin n_fail++; $display("FAIL midreset: got we=%b empty=%b count=%0d ready=%b want 0/1/0/1", mem_we, empty, count, st_ready); end
    tick();
    rst = 1'b1;
    drive(0, 0, 0, 0, 1, 0, 0);
    n_checks++; if (mem_we !== 1'b0 || empty !== 1'b1 || count !== '0 || st_ready !== 1'b1) begin n_fail++; $display("FAIL postreset: got we=%b empty=%b count=%0d ready=%b want 0/1/0/1", mem_we, empty, count, st_ready); end
  endtask

  task automatic test_full_push_pop();
    logic [31:0] exp_seq [5];
    exp_seq = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
    for (int i = 0; i < 4; i++) begin drive(1, exp_seq[i], $urandom(), 4'hF, 0, 0, 0); tick(); end
    drive(0, 0, 0, 0, 0, 0, 0);
    n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL full_count: got %0d want 4", count); end
    n_checks++; if (st_ready !== 1'b0) begin n_fail++; $display("FAIL full_st_ready: got %b want 0", st_ready); end
    drive(1, exp_seq[4], $urandom(), 4'hF, 1, 0, 0);
    n_checks++; if (st_ready !== 1'b1) begin n_fail++; $display("FAIL full_pop_st_ready: got %b want 1", st_ready); end
    n_checks++; if (mem_addr !== exp_seq[0]) begin n_fail++; $display("FAIL drain_addr0: got %h want %h", mem_addr, exp_seq[0]); end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL push_pop_count: got %0d want 4", count); end
    for (int j = 1; j < 5; j++) begin
      drive(0, 0, 0, 0, 1, 0, 0);
      n_checks++; if (mem_we !== 1'b1 || mem_addr !== exp_seq[j]) begin n_fail++; $display("FAIL drain_addr%0d: got we=%b addr=%h want 1/%h", j, mem_we, mem_addr, exp_seq[j]); end
      tick();
    end
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL drained_empty: got %b want 1", empty); end
  endtask

  task automatic test_forward();
    logic [3:0] exp_be [4];
    logic [31:0] exp_d [4];
    logic exp_st [4];
`ifdef STORE_BUF_FWD_EN
    exp_be = '{4'hF, 4'h8, 4'h0, 4'h0};
    exp_d  = '{32'hAA223344, 32'hAA000000, 32'h0, 32'h0};
    exp_st = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
    exp_be = '{4'h0, 4'h0, 4'h0, 4'h0};
    exp_d  = '{32'h0, 32'h0, 32'h0, 32'h0};
    exp_st = '{1'b1, 1'b1, 1'b0, 1'b0};
`endif
    drive(1, 32'h100, 32'h11223344, 4'hF, 0, 0, 0); tick();
    drive(1, 32'h102, 32'hAA000000, 4'h8, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 1, 32'h100);
    n_checks++; if (ld_be !== exp_be[0] || ld_data !== exp_d[0] || ld_stall !== exp_st[0]) begin n_fail++; $display("FAIL fwd_hold: got be=%h data=%h stall=%b want %h/%h/%b", ld_be, ld_data, ld_stall, exp_be[0], exp_d[0], exp_st[0]); end
    tick();
    for (int c = 0; c < 4; c++) begin
      drive(0, 0, 0, 0, 1, 1, 32'h100);
      n_checks++; if (ld_be !== exp_be[c] || ld_data !== exp_d[c] || ld_stall !== exp_st[c]) begin n_fail++; $display("FAIL fwd_drain%0d: got be=%h data=%h stall=%b want %h/%h/%b", c, ld_be, ld_data, ld_stall, exp_be[c], exp_d[c], exp_st[c]); end
      tick();
    end
  endtask

  task automatic test_no_match();
    drive(1, 32'h204, 32'hDEADBEEF, 4'hF, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 1, 32'h200);
    n_checks++; if (ld_be !== 4'h0 || ld_data !== 32'h0 || ld_stall !== 1'b0) begin n_fail++; $display("FAIL nomatch: got be=%h data=%h stall=%b want 0/0/0", ld_be, ld_data, ld_stall); end
    drive(0, 0, 0, 0, 0, 1, 32'h206);
`ifdef STORE_BUF_FWD_EN
    n_checks++; if (ld_be !== 4'hF || ld_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lsb_ignored: got be=%h data=%h want F/deadbeef", ld_be, ld_data); end
`else
    n_checks++; if (ld_stall !== 1'b1) begin n_fail++; $display("FAIL lsb_ignored: got stall=%b want 1", ld_stall); end
`endif
    drive(0, 0, 0, 0, 1, 0, 0); tick();
  endtask

  task automatic test_stream();
    sb_entry_t sent[$], got[$];
    int sent_n = 0;
    int cyc = 0;
    while ((sent_n < 20 || q.size() > 0) && cyc < 200) begin
      drive(sent_n < 20, 32'h400 + 32'(4*sent_n), $urandom(), 4'($urandom()), (cyc % 2) == 0, 0, 0);
      n_checks++; if (count > 3'd4) begin n_fail++; $display("FAIL stream_count: got %0d want <=4", count); end
      if (st_valid && st_ready) begin sent.push_back('{st_addr, st_data, st_be, st_pc}); sent_n++; end
      if (mem_we && mem_ready) got.push_back('{mem_addr, mem_data, mem_be, mem_pc});
      tick();
      cyc++;
    end
    n_checks++; if (got.size() != 20 || sent.size() != 20) begin n_fail++; $display("FAIL stream_total: got %0d drained of %0d sent want 20/20 (cycles %0d)", got.size(), sent.size(), cyc); end
    for (int i = 0; i < 20 && i < got.size() && i < sent.size(); i++) begin
      n_checks++; if (got[i] !== sent[i]) begin n_fail++; $display("FAIL stream_order%0d: got %h want %h", i, got[i], sent[i]); end
    end
  endtask

  task automatic test_random();
    logic [3:0] eb;
    logic [31:0] ed;
    logic es;
    sb_entry_t h;
    for (int c = 0; c < 400; c++) begin
      drive(1'($urandom()), 32'h300 + 32'($urandom_range(0, 3) << 2) + 32'($urandom_range(0, 3)), $urandom(),
            4'($urandom()), $urandom_range(0, 2) != 0, 1'($urandom()), 32'h300 + 32'($urandom_range(0, 15)));
      model_ld(eb, ed, es);
      n_checks++; if (st_ready !== (q.size() < DEPTH || (q.size() > 0 && mem_ready))) begin n_fail++; $display("FAIL rnd_st_ready c%0d: got %b with %0d pending", c, st_ready, q.size()); end
      n_checks++; if (count !== CNT_W'(q.size()) || empty !== (q.size() == 0) || mem_we !== (q.size() > 0)) begin n_fail++; $display("FAIL rnd_level c%0d: got count=%0d empty=%b we=%b want count=%0d", c, count, empty, mem_we, q.size()); end
      if (q.size() > 0) begin
        h = '{mem_addr, mem_data, mem_be, mem_pc};
        n_checks++; if (h !== q[0]) begin n_fail++; $display("FAIL rnd_head c%0d: got %h want %h", c, h, q[0]); end
      end
      n_checks++; if (ld_be !== eb || ld_data !== ed || ld_stall !== es) begin n_fail++; $display("FAIL rnd_load c%0d: got be=%h data=%h stall=%b want %h/%h/%b", c, ld_be, ld_data, ld_stall, eb, ed, es); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_full_push_pop();
    test_forward();
    test_no_match();
    test_stream();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/store_buffer.md
# store_buffer

Posted-write buffer between the CPU's memory-stage store port and the data memory. Stores are accepted at one per cycle and queued in a small FIFO. The FIFO drains to the data-memory write port in order as the memory accepts them. Loads are checked against pending entries so a load never returns data older than an earlier store.

## Interface
Parameters:
- DEPTH, 4, entry count; power of two, ≥2
- CNT_W, $clog2(DEPTH+1), width of `count`

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset; asynchronous, active-low (asserted at 0)
- st_valid  in  1  CPU presents a store
- st_ready  out  1  buffer can take the store this cycle
- st_addr  in  32  byte address of store
- st_data  in  32  store data, lane-aligned
- st_be  in  4  byte enables, bit i = byte lane i
- st_pc  in  32  PC of the storing instruction, carried for trace
- ld_valid  in  1  CPU presents a load
- ld_addr  in  32  load byte address
- ld_data  out  32  forwarded bytes; lanes outside `ld_be` are 0
- ld_be  out  4  lanes supplied by the buffer
- ld_stall  out  1  load must be held this cycle
- mem_we  out  1  head entry presented to the data memory
- mem_ready  in  1  data memory accepts the write this cycle
- mem_addr  out  32  head address
- mem_data  out  32  head data
- mem_be  out  4  head byte enables
- mem_pc  out  32  head PC
- empty  out  1  no pending entries
- count  out  CNT_W  number of pending entries

## Operation
- FIFO storage uses head and tail pointers of $clog2(DEPTH)+1 bits. Pointers wrap modulo 2·DEPTH.
  - full when indices are equal and MSBs differ.
  - empty when pointers are equal.
- Push: `st_valid && st_ready`. The entry {addr, data, be, pc} is written at the tail and the tail increments.
- Pop: `mem_we && mem_ready`. The head increments.
- `mem_we = !empty`. The `mem_*` outputs are driven straight from the head entry.
- `st_ready = !full || pop`. This creates a combinational path from `mem_ready` to `st_ready`.
- Simultaneous push and pop:
  - `count` is unchanged.
  - A push while full is legal only with a concurrent pop.
- `st_ready` does not depend on `st_valid`.
- A store with `st_be == 0` is accepted and queued unchanged.
- Load match condition: an entry matches when it is valid and `entry.addr[31:2] == ld_addr[31:2]`.
  - The entry being popped this cycle still counts, because the memory updates only at the edge.
- `st_addr[1:0]` is ignored for matching and is carried through to `mem_addr` unchanged.
- When `ld_valid` is 0: `ld_be = 0`, `ld_data = 0`, `ld_stall = 0`.
- `count` and `empty` are registered-state derived and valid every cycle.

## Timing
- Reset (rst low): pointers cleared and all pending stores discarded, including mid-drain. Output values during reset:
  - `mem_we = 0`, `empty = 1`, `count = 0`, `st_ready = 1`
  - `ld_be = 0`, `ld_data = 0`, `ld_stall = 0`
  - `mem_addr`, `mem_data`, `mem_be` and `mem_pc` are don't-care.
- Push-to-present latency: a store pushed in cycle t appears on `mem_*` with `mem_we` = 1 in cycle t+1, if the buffer was empty.
- Throughput: one push and one pop per cycle, sustained.
- A store pushed in cycle t is visible to the load lookup from cycle t+1.
- Order is strict FIFO. No coalescing and no reordering.

## Configuration
- `STORE_BUF_FWD_EN` defined:
  - Each byte lane takes data from the youngest matching entry whose `be` bit is set for that lane.
  - `ld_be` is the OR of the covered lanes.
  - `ld_stall` is always 0; the consumer merges `ld_data` over the memory data using `ld_be`.
- `STORE_BUF_FWD_EN` undefined:
  - `ld_be = 0` and `ld_data = 0` always.
  - `ld_stall = ld_valid && any match`. The stall holds until the matching entries drain.

## Structure
- Package `store_buf_pkg`:
  - `sb_entry_t` struct {addr[31:0], data[31:0], be[3:0], pc[31:0]}
  - `BE_W = 4`
- Sub-module `sb_fwd_lookup`: combinational per-lane youngest-match priority select. It takes the entry array, a valid mask and the head pointer, and returns `ld_data`/`ld_be`. It is instantiated only under `STORE_BUF_FWD_EN`.

## Test plan
- Reset while 3 entries are pending and `mem_ready` = 0, then release reset → `mem_we` = 0, `count` = 0, `empty` = 1, `st_ready` = 1.
- Hold `mem_ready` = 0 and push 4 stores to 0x0, 0x4, 0x8, 0xC → `count` = 4 and `st_ready` = 0. Then set `mem_ready` = 1 and push a fifth store (0x10) in the same cycle → the push is accepted and `count` stays 4. Drain → `mem_addr` sequence is 0x0, 0x4, 0x8, 0xC, 0x10.
- With FWD enabled:
  - Push a store to 0x100, data 0x11223344, be 4'b1111.
  - Then push a store to 0x102, data 0xAA000000, be 4'b1000.
  - Hold `mem_ready` = 0 and load 0x100 → `ld_be` = 4'b1111, `ld_data` = 0xAA223344, `ld_stall` = 0.
- With FWD disabled, same stimulus → `ld_stall` = 1 until both entries have popped; afterwards `ld_stall` = 0 and `ld_be` = 0.
- Stream 20 stores with `mem_ready` toggling 1,0,1,0… → every store reaches the memory exactly once, in order, and `count` never exceeds 4.
- Load to 0x200 with a pending store only to 0x204 → `ld_be` = 0 and `ld_stall` = 0 in both configurations.
